frame_plot_sequencer: RTL

//  Sequences the shared VGA pixel-plot port on behalf of the game state FSM.
//  - One erase or draw command walks every game object in turn.
//  - Each object is a BOX_W x BOX_H box; the block emits one plot per pixel.
//  - The state FSM pulses start_erase / start_draw and waits for done before it advances.

---
 rtl/frame_plot_pkg.sv | 32 +++
 rtl/frame_plot_sequencer_box_pixel_counter.sv | 52 +++++
 rtl/frame_plot_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_plot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_plot_pkg
// Description : Shared state/command encodings and sizing helper for the
//               frame plot sequencer and its pixel counter.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_plot_pkg;

    // Sequencer states
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] PLOT  = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;

    // Latched command
    localparam logic [1:0] CMD_ERASE = 2'd0;
    localparam logic [1:0] CMD_DRAW  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;

    // Colour written by a full-screen clear
    localparam int CLEAR_COLOR = 0;

    // Index width for a range of n values, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_plot_sequencer_box_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : box_pixel_counter
// Description : Row-major W x H pixel counter. cx runs 0..W-1 and wraps,
//               stepping cy; cy wraps after H-1. clr has priority over en.
// Ports       : clk, rst (sync, active-high), clr, en -> cx, cy, last
//               last = (cx == W-1) && (cy == H-1)
// Revision    : 1.0 - initial release
// ============================================================================
module box_pixel_counter
    import frame_plot_pkg::*;
#(
    parameter int W = 4,
    parameter int H = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic [idx_width(W)-1:0] cx,
    output logic [idx_width(H)-1:0] cy,
    output logic                    last
);

    localparam int CX_W = idx_width(W);
    localparam int CY_W = idx_width(H);
    localparam logic [CX_W-1:0] C_CX_MAX = CX_W'(W - 1);
    localparam logic [CY_W-1:0] C_CY_MAX = CY_W'(H - 1);

    logic [CX_W-1:0] r_cx;
    logic [CY_W-1:0] r_cy;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (en) begin
            if (r_cx == C_CX_MAX) begin
                r_cx <= '0;
                r_cy <= (r_cy == C_CY_MAX) ? '0 : r_cy + CY_W'(1);
            end else begin
                r_cx <= r_cx + CX_W'(1);
            end
        end
    end

    assign cx   = r_cx;
    assign cy   = r_cy;
    assign last = (r_cx == C_CX_MAX) && (r_cy == C_CY_MAX);

endmodule
`default_nettype wire

// File: rtl/frame_plot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_plot_sequencer
// Description : Drives the shared VGA plot port for the game FSM. An erase or
//               draw command walks all NUM_OBJ objects, plotting each
//               BOX_W x BOX_H box row-major; off-screen pixels are suppressed.
// Ports       : clk, reset (sync, active-high)
//               start_erase/start_draw/start_clear : 1-cycle commands
//               obj_idx -> obj_x/obj_y/obj_color  : object lookup
//               plot, plot_x, plot_y, plot_color   : registered pixel write
//               busy (state != IDLE), done (1-cycle completion pulse)
// Options     : PLOT_CLEAR_EN - enables the full-screen CLEAR sweep driven by
//               start_clear; otherwise start_clear is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_plot_sequencer
    import frame_plot_pkg::*;
#(
    parameter int NUM_OBJ  = 4,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_erase,
    input  logic                          start_draw,
    input  logic                          start_clear,
    output logic [idx_width(NUM_OBJ)-1:0] obj_idx,
    input  logic [X_W-1:0]                obj_x,
    input  logic [Y_W-1:0]                obj_y,
    input  logic [COLOR_W-1:0]            obj_color,
    output logic                          plot,
    output logic [X_W-1:0]                plot_x,
    output logic [Y_W-1:0]                plot_y,
    output logic [COLOR_W-1:0]            plot_color,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = idx_width(NUM_OBJ);
    localparam int BCX_W = idx_width(BOX_W);
    localparam int BCY_W = idx_width(BOX_H);

    logic [2:0]         r_state;
    logic [2:0]         w_state_d;
    logic [1:0]         r_cmd;
    logic [IDX_W-1:0]   r_obj_idx;
    logic [X_W-1:0]     r_base_x;
    logic [Y_W-1:0]     r_base_y;
    logic [COLOR_W-1:0] r_color;
    logic               r_plot;
    logic [X_W-1:0]     r_plot_x;
    logic [Y_W-1:0]     r_plot_y;
    logic [COLOR_W-1:0] r_plot_color;
    logic               r_done;
    logic               r_pix_last;     // pixel now on the port is the box's last

    logic               w_take_clear;
    logic               w_take_box;
    logic [1:0]         w_new_cmd;
    logic               w_idx_last;
    logic               w_load_pix;
    logic               w_box_clr;
    logic [BCX_W-1:0]   w_box_cx;
    logic [BCY_W-1:0]   w_box_cy;
    logic               w_box_last;
    logic [X_W-1:0]     w_src_x;
    logic [Y_W-1:0]     w_src_y;
    logic [COLOR_W-1:0] w_src_color;
    logic [X_W:0]       w_sum_x;
    logic [Y_W:0]       w_sum_y;
    logic               w_in_range;

`ifdef PLOT_CLEAR_EN
    logic                             r_clr_last;
    logic                             w_load_clr;
    logic                             w_clr_clr;
    logic [idx_width(SCREEN_W)-1:0]   w_clr_cx;
    logic [idx_width(SCREEN_H)-1:0]   w_clr_cy;
    logic                             w_clr_last;

    assign w_take_clear = (r_state == IDLE) && start_clear;
`else
    logic w_unused_clear;

    assign w_unused_clear = start_clear;
    assign w_take_clear   = 1'b0;
`endif

    // Commands are only honoured in IDLE; clear outranks erase outranks draw.
    assign w_take_box = (r_state == IDLE) && !w_take_clear && (start_erase || start_draw);
    assign w_new_cmd  = start_erase ? CMD_ERASE : CMD_DRAW;
    assign w_idx_last = (r_obj_idx == IDX_W'(NUM_OBJ - 1));

    // The plot port is registered, so the pixel shown in a PLOT cycle is
    // computed one cycle earlier: LOAD prepares pixel 0 straight from the
    // object inputs, and each PLOT cycle prepares the following pixel.
    assign w_load_pix = (r_state == LOAD) || ((r_state == PLOT) && !r_pix_last);

    // The box counter sits at zero outside LOAD/PLOT, so each LOAD starts the
    // box at (0,0) and steps once per prepared pixel.
    assign w_box_clr = !((r_state == LOAD) || (r_state == PLOT));

    box_pixel_counter #(
        .W (BOX_W),
        .H (BOX_H)
    ) u_box_cnt (
        .clk  (clk),
        .rst  (reset),
        .clr  (w_box_clr),
        .en   (w_load_pix),
        .cx   (w_box_cx),
        .cy   (w_box_cy),
        .last (w_box_last)
    );

    assign w_src_x     = (r_state == LOAD) ? obj_x : r_base_x;
    assign w_src_y     = (r_state == LOAD) ? obj_y : r_base_y;
    assign w_src_color = (r_state == LOAD) ? ((r_cmd == CMD_ERASE) ? '0 : obj_color)
                                           : r_color;

    // One extra bit keeps a wrapped coordinate from landing back on screen.
    assign w_sum_x    = {1'b0, w_src_x} + (X_W + 1)'(w_box_cx);
    assign w_sum_y    = {1'b0, w_src_y} + (Y_W + 1)'(w_box_cy);
    assign w_in_range = (32'(w_sum_x) < 32'(SCREEN_W)) && (32'(w_sum_y) < 32'(SCREEN_H));

`ifdef PLOT_CLEAR_EN
    assign w_load_clr = w_take_clear || ((r_state == CLEAR) && !r_clr_last);
    assign w_clr_clr  = !((r_state == IDLE) || (r_state == CLEAR));

    box_pixel_counter #(
        .W (SCREEN_W),
        .H (SCREEN_H)
    ) u_clr_cnt (
        .clk  (clk),
        .rst  (reset),
        .clr  (w_clr_clr),
        .en   (w_load_clr),
        .cx   (w_clr_cx),
        .cy   (w_clr_cy),
        .last (w_clr_last)
    );
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_clear) begin
                    w_state_d = CLEAR;
                end else if (w_take_box) begin
                    w_state_d = LOAD;
                end
            end
            LOAD: w_state_d = PLOT;
            PLOT: begin
                if (r_pix_last) begin
                    w_state_d = NEXT;
                end
            end
            NEXT: w_state_d = w_idx_last ? DONE : LOAD;
            DONE: w_state_d = IDLE;
`ifdef PLOT_CLEAR_EN
            CLEAR: begin
                if (r_clr_last) begin
                    w_state_d = DONE;
                end
            end
`endif
            default: w_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd        <= CMD_ERASE;
            r_obj_idx    <= '0;
            r_base_x     <= '0;
            r_base_y     <= '0;
            r_color      <= '0;
            r_plot       <= 1'b0;
            r_plot_x     <= '0;
            r_plot_y     <= '0;
            r_plot_color <= '0;
            r_done       <= 1'b0;
            r_pix_last   <= 1'b0;
`ifdef PLOT_CLEAR_EN
            r_clr_last   <= 1'b0;
`endif
        end else begin
            r_done     <= (w_state_d == DONE);
            r_plot     <= 1'b0;
            r_pix_last <= 1'b0;

            if (w_take_box) begin
                r_cmd <= w_new_cmd;
            end

            if (r_state == LOAD) begin
                r_base_x <= obj_x;
                r_base_y <= obj_y;
                r_color  <= w_src_color;
            end

            if ((r_state == NEXT) && !w_idx_last) begin
                r_obj_idx <= r_obj_idx + IDX_W'(1);
            end
            if (w_state_d == DONE) begin
                r_obj_idx <= '0;
            end

            if (w_load_pix) begin
                r_plot       <= w_in_range;
                r_plot_x     <= w_sum_x[X_W-1:0];
                r_plot_y     <= w_sum_y[Y_W-1:0];
                r_plot_color <= w_src_color;
                r_pix_last   <= w_box_last;
            end

`ifdef PLOT_CLEAR_EN
            r_clr_last <= 1'b0;
            if (w_take_clear) begin
                r_cmd <= CMD_CLEAR;
            end
            if (w_load_clr) begin
                r_plot       <= 1'b1;
                r_plot_x     <= X_W'(w_clr_cx);
                r_plot_y     <= Y_W'(w_clr_cy);
                r_plot_color <= COLOR_W'(CLEAR_COLOR);
                r_clr_last   <= w_clr_last;
            end
`endif
        end
    end

    assign obj_idx    = r_obj_idx;
    assign plot       = r_plot;
    assign plot_x     = r_plot_x;
    assign plot_y     = r_plot_y;
    assign plot_color = r_plot_color;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule
`default_nettype wire
